ins_fetch: RTL and testbench

Instruction fetch unit. It requests 32-bit instructions from the memory controller one at a time, pre-decodes each one for control flow, and predicts the next PC with a 2-bit branch history table (BHT). Fetched entries are buffered in a small queue and handed to the issue stage as one registered packet per cycle: `oIS_En`, `oIS_Ins`, `oIS_Bj`, `oIS_Pc`, `oIS_Pjt`. The ROB redirects fetch on a misprediction and trains the BHT.

---
 rtl/ins_fetch.sv | 114 +++++++++++
 tb/tb_ins_fetch.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// ins_fetch: single-outstanding instruction fetch with JAL/branch pre-decode,
// 2-bit BHT next-PC prediction and a small queue feeding one issue packet per cycle.
module ins_fetch #(
  parameter int DEPTH = 4,
  parameter int BHT_N = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        oMC_En,
  output logic [31:0] oMC_Addr,
  input  logic        iMC_En,
  input  logic [31:0] iMC_Ins,
  input  logic        iFull,
  output logic        oIS_En,
  output logic [31:0] oIS_Ins,
  output logic        oIS_Bj,
  output logic [31:0] oIS_Pc,
  output logic [31:0] oIS_Pjt,
  input  logic        iROB_Flush,
  input  logic [31:0] iROB_Pc,
  input  logic        iROB_Upd,
  input  logic [31:0] iROB_UpdPc,
  input  logic        iROB_UpdTaken
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BHT_N);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_fetch_pc;
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0] r_cnt;
  logic [31:0] r_q_ins [DEPTH];
  logic r_q_bj [DEPTH];
  logic [31:0] r_q_pc [DEPTH];
  logic [31:0] r_q_pjt [DEPTH];
  logic [1:0] r_bht [BHT_N];
  logic [BW-1:0] w_idx, w_uidx;
  logic [31:0] w_jimm, w_bimm, w_pjt;
  logic w_jal, w_br, w_bj, w_room, w_req, w_push, w_pop, w_unused;
  assign w_unused = ^{iROB_UpdPc[31:BW+2], iROB_UpdPc[1:0]};
  assign w_idx = r_fetch_pc[BW+1:2];
  assign w_uidx = iROB_UpdPc[BW+1:2];
  assign w_jal = iMC_Ins[6:0] == 7'b1101111;
  assign w_br = iMC_Ins[6:0] == 7'b1100011;
  assign w_bj = w_jal | (w_br & r_bht[w_idx][1]);
  assign w_jimm = {{12{iMC_Ins[31]}}, iMC_Ins[19:12], iMC_Ins[20], iMC_Ins[30:21], 1'b0};
  assign w_bimm = {{20{iMC_Ins[31]}}, iMC_Ins[7], iMC_Ins[30:25], iMC_Ins[11:8], 1'b0};
  assign w_pjt = r_fetch_pc + (w_jal ? w_jimm : w_bj ? w_bimm : 32'd4);
  assign w_room = r_cnt < (AW+1)'(DEPTH);
  assign w_req = en & ~iROB_Flush & (r_state == REQ) & w_room;
  assign w_push = en & ~iROB_Flush & (r_state == WAIT) & iMC_En;
  assign w_pop = en & ~iROB_Flush & ~iFull & (r_cnt != '0);
  always_comb begin
    w_next = r_state;
    if (en && iROB_Flush) w_next = (r_state != REQ && !iMC_En) ? DROP : REQ;
    else if (en && r_state == REQ) w_next = w_room ? WAIT : REQ;
    else if (en && iMC_En) w_next = REQ;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= REQ;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_ins[r_tail] <= iMC_Ins;
      r_q_bj[r_tail] <= w_bj;
      r_q_pc[r_tail] <= r_fetch_pc;
      r_q_pjt[r_tail] <= w_pjt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oMC_En <= 1'b0;
      oMC_Addr <= '0;
      oIS_En <= 1'b0;
      oIS_Ins <= '0;
      oIS_Bj <= 1'b0;
      oIS_Pc <= '0;
      oIS_Pjt <= '0;
      r_fetch_pc <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt <= '0;
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
    end else if (en) begin
      oMC_En <= w_req;
      if (w_req) oMC_Addr <= r_fetch_pc;
      oIS_En <= w_pop;
      oIS_Ins <= w_pop ? r_q_ins[r_head] : '0;
      oIS_Bj <= w_pop & r_q_bj[r_head];
      oIS_Pc <= w_pop ? r_q_pc[r_head] : '0;
      oIS_Pjt <= w_pop ? r_q_pjt[r_head] : '0;
      if (iROB_Flush) begin
        r_fetch_pc <= iROB_Pc;
        r_head <= '0;
        r_tail <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_fetch_pc <= w_pjt;
        r_head <= r_head + AW'(w_pop);
        r_tail <= r_tail + AW'(w_push);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
      // saturating update; a same-cycle lookup reads the old value
      if (iROB_Upd)
        r_bht[w_uidx] <= iROB_UpdTaken ? (r_bht[w_uidx] == 2'b11 ? 2'b11 : r_bht[w_uidx] + 2'b01)
                                       : (r_bht[w_uidx] == 2'b00 ? 2'b00 : r_bht[w_uidx] - 2'b01);
    end else begin
      oMC_En <= 1'b0;
      oIS_En <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: memory responder plus scoreboard of predicted issue packets,
// with one task per scenario checking request/issue behaviour.
module tb_ins_fetch;
  typedef struct {
    logic [31:0] ins;
    logic        bj;
    logic [31:0] pc;
    logic [31:0] pjt;
  } ent_t;
  logic clk = 0, rst = 1, en = 0, iMC_En = 0, iFull = 0;
  logic iROB_Flush = 0, iROB_Upd = 0, iROB_UpdTaken = 0;
  logic [31:0] iMC_Ins = '0, iROB_Pc = '0, iROB_UpdPc = '0;
  logic oMC_En, oIS_En, oIS_Bj;
  logic [31:0] oMC_Addr, oIS_Ins, oIS_Pc, oIS_Pjt;
  int checks = 0, errors = 0, cyc = 0;
  ent_t sb[$], iss_log[$];
  int iss_cyc[$];
  logic [31:0] req_log[$];
  bit pend = 0, stale = 0;
  int cnt = 0, lat = 2;
  logic [31:0] paddr = '0;
  int bht_m[16];

  ins_fetch dut (
    .clk(clk), .rst(rst), .en(en),
    .oMC_En(oMC_En), .oMC_Addr(oMC_Addr), .iMC_En(iMC_En), .iMC_Ins(iMC_Ins),
    .iFull(iFull), .oIS_En(oIS_En), .oIS_Ins(oIS_Ins), .oIS_Bj(oIS_Bj),
    .oIS_Pc(oIS_Pc), .oIS_Pjt(oIS_Pjt), .iROB_Flush(iROB_Flush), .iROB_Pc(iROB_Pc),
    .iROB_Upd(iROB_Upd), .iROB_UpdPc(iROB_UpdPc), .iROB_UpdTaken(iROB_UpdTaken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h10) return 32'h0200006F;
    if (a == 32'h40) return 32'hFE101CE3;
    return 32'h00100093;
  endfunction

  function automatic ent_t predecode(input logic [31:0] pc, input logic [31:0] ins);
    ent_t e;
    int off;
    e.ins = ins; e.pc = pc; e.bj = 0; e.pjt = pc + 32'd4;
    if (ins[6:0] == 7'h6F) begin
      off = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      e.bj = 1; e.pjt = pc + off;
    end else if (ins[6:0] == 7'h63 && bht_m[pc[5:2]] >= 2) begin
      off = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      e.bj = 1; e.pjt = pc + off;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    ent_t e, x;
    iMC_En = 0;
    if (rst) begin
      pend = 0; stale = 0; sb.delete();
      for (int i = 0; i < 16; i++) bht_m[i] = 1;
    end else begin
      if (oIS_En) begin
        e.ins = oIS_Ins; e.bj = oIS_Bj; e.pc = oIS_Pc; e.pjt = oIS_Pjt;
        iss_log.push_back(e); iss_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_issue: unexpected packet pc=%h ins=%h", oIS_Pc, oIS_Ins);
        end else begin
          x = sb.pop_front();
          if ({e.ins, e.bj, e.pc, e.pjt} !== {x.ins, x.bj, x.pc, x.pjt}) begin
            errors++;
            $display("FAIL sb_packet: got ins=%h bj=%b pc=%h pjt=%h want ins=%h bj=%b pc=%h pjt=%h",
                     e.ins, e.bj, e.pc, e.pjt, x.ins, x.bj, x.pc, x.pjt);
          end
        end
      end
      if (en && pend) begin
        if (cnt == 0) begin
          iMC_En = 1; iMC_Ins = mem_rd(paddr);
          if (!stale) sb.push_back(predecode(paddr, iMC_Ins));
          pend = 0;
        end else cnt--;
      end
      if (oMC_En) begin
        req_log.push_back(oMC_Addr);
        pend = 1; stale = 0; paddr = oMC_Addr; cnt = lat - 1;
      end
      if (en && iROB_Flush) begin
        sb.delete();
        if (pend) stale = 1;
      end
      if (en && iROB_Upd)
        bht_m[iROB_UpdPc[5:2]] = iROB_UpdTaken ? (bht_m[iROB_UpdPc[5:2]] == 3 ? 3 : bht_m[iROB_UpdPc[5:2]] + 1)
                                               : (bht_m[iROB_UpdPc[5:2]] == 0 ? 0 : bht_m[iROB_UpdPc[5:2]] - 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    iss_log.delete(); iss_cyc.delete(); req_log.delete();
  endtask

  task automatic redirect(input logic [31:0] pc);
    iROB_Flush = 1; iROB_Pc = pc;
    step(1);
    iROB_Flush = 0;
    clear_logs();
  endtask

  task automatic wait_iss(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && iss_log.size() < n; i++) step(1);
    ok = iss_log.size() >= n;
  endtask

  task automatic wait_req(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && req_log.size() < n; i++) step(1);
    ok = req_log.size() >= n;
  endtask

  task automatic wait_mc(input logic [31:0] a, output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (oMC_En && oMC_Addr == a) ok = 1;
      else step(1);
    end
  endtask

  task automatic fetch_one(input logic [31:0] pc, output ent_t e, output bit ok);
    redirect(pc);
    wait_iss(1, 40, ok);
    if (ok) e = iss_log[0];
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input int n);
    iROB_Upd = 1; iROB_UpdPc = pc; iROB_UpdTaken = taken;
    step(n);
    iROB_Upd = 0;
  endtask

  task automatic test_reset();
    step(1);
    checks++;
    if ({oMC_En, oIS_En, oIS_Bj} !== 3'b000 || oMC_Addr !== 0) begin
      errors++;
      $display("FAIL reset_ctrl: mc_en=%b is_en=%b bj=%b addr=%h, want all 0", oMC_En, oIS_En, oIS_Bj, oMC_Addr);
    end
    checks++;
    if (oIS_Ins !== 0 || oIS_Pc !== 0 || oIS_Pjt !== 0) begin
      errors++;
      $display("FAIL reset_data: ins=%h pc=%h pjt=%h, want 0", oIS_Ins, oIS_Pc, oIS_Pjt);
    end
    rst = 0; en = 1;
    step(1);
    checks++;
    if (oMC_En !== 1 || oMC_Addr !== 0) begin
      errors++;
      $display("FAIL first_req: mc_en=%b addr=%h, want 1/00000000", oMC_En, oMC_Addr);
    end
  endtask

  task automatic test_straight();
    bit ok;
    wait_iss(3, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL straight_timeout: issued %0d, want 3", iss_log.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (iss_log[i].pc !== 32'(4 * i) || iss_log[i].bj !== 0 || iss_log[i].pjt !== 32'(4 * i + 4) || iss_log[i].ins !== 32'h00100093) begin
          errors++;
          $display("FAIL straight_%0d: pc=%h bj=%b pjt=%h ins=%h, want pc=%h bj=0 pjt=%h ins=00100093",
                   i, iss_log[i].pc, iss_log[i].bj, iss_log[i].pjt, iss_log[i].ins, 4 * i, 4 * i + 4);
        end
      end
  endtask

  task automatic test_jal();
    ent_t e;
    bit ok;
    fetch_one(32'h10, e, ok);
    checks++;
    if (!ok || e.pc !== 32'h10 || e.bj !== 1 || e.pjt !== 32'h30) begin
      errors++;
      $display("FAIL jal_issue: ok=%b pc=%h bj=%b pjt=%h, want pc=10 bj=1 pjt=30", ok, e.pc, e.bj, e.pjt);
    end
    wait_req(2, 40, ok);
    checks++;
    if (!ok || req_log[0] !== 32'h10 || req_log[1] !== 32'h30) begin
      errors++;
      $display("FAIL jal_next_req: ok=%b reqs=%0d second=%h, want 10 then 30", ok, req_log.size(), ok ? req_log[1] : 32'h0);
    end
  endtask

  task automatic test_bht();
    ent_t e;
    bit ok;
    fetch_one(32'h40, e, ok);
    checks++;
    if (!ok || e.bj !== 0 || e.pjt !== 32'h44) begin
      errors++;
      $display("FAIL bht_init: ok=%b bj=%b pjt=%h, want bj=0 pjt=44", ok, e.bj, e.pjt);
    end
    train(32'h40, 1, 2);
    fetch_one(32'h40, e, ok);
    checks++;
    if (!ok || e.bj !== 1 || e.pjt !== 32'h38) begin
      errors++;
      $display("FAIL bht_taken: ok=%b bj=%b pjt=%h, want bj=1 pjt=38", ok, e.bj, e.pjt);
    end
    train(32'h40, 0, 3);
    fetch_one(32'h40, e, ok);
    checks++;
    if (!ok || e.bj !== 0 || e.pjt !== 32'h44) begin
      errors++;
      $display("FAIL bht_not_taken: ok=%b bj=%b pjt=%h, want bj=0 pjt=44", ok, e.bj, e.pjt);
    end
    train(32'h40, 0, 1);
    train(32'h40, 1, 1);
    fetch_one(32'h40, e, ok);
    checks++;
    if (!ok || e.bj !== 0) begin
      errors++;
      $display("FAIL bht_sat_low: ok=%b bj=%b, want bj=0", ok, e.bj);
    end
    train(32'h40, 1, 1);
    fetch_one(32'h40, e, ok);
    checks++;
    if (!ok || e.bj !== 1 || e.pjt !== 32'h38) begin
      errors++;
      $display("FAIL bht_recover: ok=%b bj=%b pjt=%h, want bj=1 pjt=38", ok, e.bj, e.pjt);
    end
  endtask

  task automatic test_flush_wait();
    bit ok;
    redirect(32'h20);
    wait_mc(32'h20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_setup: no request to 00000020 seen");
    end
    iROB_Flush = 1; iROB_Pc = 32'h100;
    step(1);
    iROB_Flush = 0;
    clear_logs();
    wait_req(1, 40, ok);
    checks++;
    if (!ok || req_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL flush_req: ok=%b addr=%h, want 00000100", ok, ok ? req_log[0] : 32'h0);
    end
    wait_iss(1, 40, ok);
    checks++;
    if (!ok || iss_log[0].pc !== 32'h100) begin
      errors++;
      $display("FAIL flush_drop: ok=%b first issued pc=%h, want 00000100", ok, ok ? iss_log[0].pc : 32'h0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    iFull = 1;
    redirect(32'h200);
    step(40);
    checks++;
    if (req_log.size() != 4 || oMC_En !== 0 || iss_log.size() != 0) begin
      errors++;
      $display("FAIL bp_hold: reqs=%0d mc_en=%b issued=%0d, want 4/0/0", req_log.size(), oMC_En, iss_log.size());
    end
    iFull = 0;
    wait_iss(4, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: issued %0d, want 4", iss_log.size());
    end else
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (iss_log[i].pc !== 32'h200 + 32'(4 * i) || iss_cyc[i] != iss_cyc[0] + i) begin
          errors++;
          $display("FAIL bp_order_%0d: pc=%h cyc=%0d, want pc=%h cyc=%0d", i, iss_log[i].pc, iss_cyc[i], 32'h200 + 4 * i, iss_cyc[0] + i);
        end
      end
    wait_req(5, 30, ok);
    checks++;
    if (!ok || req_log[4] !== 32'h210) begin
      errors++;
      $display("FAIL bp_resume: ok=%b addr=%h, want 00000210", ok, ok ? req_log[4] : 32'h0);
    end
  endtask

  task automatic test_freeze();
    bit ok;
    redirect(32'h300);
    wait_mc(32'h300, ok);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if (!ok || oMC_En !== 0 || oIS_En !== 0 || oMC_Addr !== 32'h300) begin
        errors++;
        $display("FAIL freeze_%0d: ok=%b mc_en=%b is_en=%b addr=%h, want 0/0/00000300", i, ok, oMC_En, oIS_En, oMC_Addr);
      end
    end
    en = 1;
    wait_req(2, 40, ok);
    checks++;
    if (!ok || req_log[0] !== 32'h300 || req_log[1] !== 32'h304) begin
      errors++;
      $display("FAIL freeze_resume: ok=%b reqs=%0d, want 00000300 then 00000304", ok, req_log.size());
    end
    checks++;
    if (iss_log.size() == 0 || iss_log[0].pc !== 32'h300) begin
      errors++;
      $display("FAIL freeze_issue: issued=%0d, want first pc 00000300", iss_log.size());
    end
  endtask

  task automatic test_async_reset();
    ent_t e;
    bit ok;
    train(32'h40, 1, 2);
    step(3);
    rst = 1;
    #1;
    checks++;
    if ({oMC_En, oIS_En, oIS_Bj} !== 3'b000 || oMC_Addr !== 0 || oIS_Ins !== 0 || oIS_Pc !== 0 || oIS_Pjt !== 0) begin
      errors++;
      $display("FAIL async_reset: mc_en=%b addr=%h is_en=%b pc=%h pjt=%h, want all 0", oMC_En, oMC_Addr, oIS_En, oIS_Pc, oIS_Pjt);
    end
    step(2);
    rst = 0;
    fetch_one(32'h40, e, ok);
    checks++;
    if (!ok || e.bj !== 0 || e.pjt !== 32'h44) begin
      errors++;
      $display("FAIL reset_bht: ok=%b bj=%b pjt=%h, want bj=0 pjt=44", ok, e.bj, e.pjt);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_jal();
    test_bht();
    test_flush_wait();
    test_backpressure();
    test_freeze();
    test_async_reset();
    step(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
